// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial KMP sequence detector with match counter
//
// Detects a LEN-bit PATTERN on a 1-bit serial stream, MSB of PATTERN first.
// The state is the number of pattern bits currently matched (0..LEN-1).
// The next-state tables are built at elaboration from PATTERN.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   en         sample enable, x_in is consumed only when en=1
//   clr        synchronous clear of state, match_q and match_cnt (beats en)
//   x_in       serial data bit
//   y_out      combinational Mealy match, same cycle as the final pattern bit
//   match_q    y_out registered one cycle later
//   match_cnt  saturating count of matches since reset/clr
//   state_o    current number of matched pattern bits
module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    x_in,
  output logic                    y_out,
  output logic                    match_q,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [$clog2(LEN)-1:0]  state_o
);

  localparam int SW = $clog2(LEN);
  localparam logic [SW-1:0]    LAST    = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (LEN < 2 || LEN > 16) begin : g_bad_len
    $error("seq_detector_param: LEN must be in 2..16");
  end

  // Next state from Sk on bit b: the longest suffix of (prefix_k, b) that is
  // also a pattern prefix, capped at LEN-1. Capping makes a full match land on
  // the longest proper border of PATTERN, which is the overlapping restart.
  function automatic int delta(int k, logic b);
    logic [31:0] p;
    logic [31:0] t;
    logic [31:0] m;
    int          best;
    int          lim;
    p    = 32'(PATTERN);
    t    = ((p >> (LEN - k)) << 1) | 32'(b);
    lim  = (k + 1 < LEN) ? k + 1 : LEN - 1;
    best = 0;
    for (int j = 1; j <= lim; j++) begin
      m = (32'd1 << j) - 32'd1;
      if ((t & m) == (p >> (LEN - j))) best = j;
    end
    if (!OVERLAP && k == LEN - 1 && b == PATTERN[0]) best = 0;
    return best;
  endfunction

  logic [SW-1:0] nxt0 [LEN];
  logic [SW-1:0] nxt1 [LEN];

  for (genvar k = 0; k < LEN; k++) begin : g_tbl
    localparam int N0 = delta(k, 1'b0);
    localparam int N1 = delta(k, 1'b1);
    assign nxt0[k] = SW'(N0);
    assign nxt1[k] = SW'(N1);
  end

  logic [SW-1:0] state;

  assign state_o = state;
  assign y_out   = en & ~clr & (state == LAST) & (x_in == PATTERN[0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= y_out;
      if (clr) begin
        state     <= '0;
        match_cnt <= '0;
      end else if (en) begin
        state <= x_in ? nxt1[state] : nxt0[state];
        if (y_out && match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
